// File: rtl/cla_serial_adder.sv
// Serial wide adder: one 4-bit CLA slice, one nibble per clock, LSB first.
// Ports: clk, rst_n, start, a, b, cin, [sub], busy, done, sum, cout, overflow.
// Subtraction (sub port) exists only when CLA_SUB_EN is defined.

module generic_cla (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c0,
  output logic [3:0] s,
  output logic       c4
);
  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c[0] = c0;
    c[1] = g[0] | (p[0] & c0);
    c[2] = g[1] | (p[1] & g[0])
         | (p[1] & p[0] & c0);
    c[3] = g[2] | (p[2] & g[1])
         | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & c0);
    c[4] = g[3] | (p[3] & g[2])
         | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c0);
    s    = p ^ c[3:0];
    c4   = c[4];
  end
endmodule

module cla_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef CLA_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);
  localparam int NIBBLES = WIDTH / 4;
  localparam int IW = $clog2(NIBBLES);
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             carry;
  logic [IW-1:0]    idx;
  logic [3:0]       ns;
  logic             nc;

  generic_cla u_slice (
    .a  (opa[4*idx +: 4]),
    .b  (opb[4*idx +: 4]),
    .c0 (carry),
    .s  (ns),
    .c4 (nc)
  );

  // DONE spans two cycles: a settle cycle, then the done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      opa      <= '0;
      opb      <= '0;
      carry    <= 1'b0;
      idx      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            opa <= a;
`ifdef CLA_SUB_EN
            opb   <= sub ? ~b : b;
            carry <= sub ? 1'b1 : cin;
`else
            opb   <= b;
            carry <= cin;
`endif
            idx   <= '0;
            sum   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          sum[4*idx +: 4] <= ns;
          carry <= nc;
          idx   <= idx + 1'b1;
          if (idx == LAST) begin
            idx      <= '0;
            cout     <= nc;
            overflow <= (opa[WIDTH-1] == opb[WIDTH-1])
                     && (ns[3] != opa[WIDTH-1]);
            state    <= DONE;
          end
        end
        DONE: begin
          if (!done) begin
            done <= 1'b1;
          end else begin
            done  <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cla_serial_adder.sv
// Scoreboard bench for cla_serial_adder, WIDTH=16.
// Expected results are queued at issue and popped when done pulses.

module tb_cla_serial_adder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        cin = 1'b0;
`ifdef CLA_SUB_EN
  logic        sub = 1'b0;
`endif
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        cout;
  logic        overflow;

  int pass = 0;
  int total = 0;

  // {overflow, cout, sum}
  logic [17:0] exp_q[$];

  always #5 clk = ~clk;

  cla_serial_adder #(.WIDTH(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .cin      (cin),
`ifdef CLA_SUB_EN
    .sub      (sub),
`endif
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow)
  );

  function automatic logic [17:0] model(
    input logic [15:0] x, input logic [15:0] y,
    input logic c, input logic s);
    logic [15:0] yy;
    logic        cc;
    logic [16:0] r;
    logic        v;
    yy = s ? ~y : y;
    cc = s ? 1'b1 : c;
    r  = {1'b0, x} + {1'b0, yy} + {16'd0, cc};
    v  = (x[15] == yy[15]) && (r[15] != x[15]);
    return {v, r[16], r[15:0]};
  endfunction

  // Issue one op; wait (bounded) for done. hold keeps start high and
  // scrambles a while busy. lat = posedges from accept to done seen.
  task automatic issue(
    input logic [15:0] x, input logic [15:0] y,
    input logic c, input logic s, input bit hold,
    output int lat, output logic [17:0] got,
    output int pulses);
    int n;
    @(negedge clk);
    a = x; b = y; cin = c; start = 1'b1;
`ifdef CLA_SUB_EN
    sub = s;
`endif
    exp_q.push_back(model(x, y, c, s));
    @(posedge clk);
    @(negedge clk);
    if (!hold) start = 1'b0;
    n = 0;
    pulses = 0;
    while (done !== 1'b1 && n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      a = 16'($urandom);
      b = 16'($urandom);
      cin = 1'($urandom);
    end
    start = 1'b0;
    lat = (done === 1'b1) ? n : -1;
    got = {overflow, cout, sum};
    if (done === 1'b1) pulses = 1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
  endtask

  task automatic test_reset;
    total++;
    if ({busy, done, sum, cout, overflow} !== 20'd0) begin
      $display("FAIL reset: got %h want 0",
               {busy, done, sum, cout, overflow});
    end else pass++;
  endtask

  task automatic test_vec(input string nm,
    input logic [15:0] x, input logic [15:0] y,
    input logic c, input logic s);
    int lat;
    int pl;
    logic [17:0] got;
    logic [17:0] e;
    issue(x, y, c, s, 1'b0, lat, got, pl);
    e = exp_q.pop_front();
    total++;
    if (got !== e) begin
      $display("FAIL %s result: got %h want %h", nm, got, e);
    end else pass++;
    total++;
    if (lat != 5) begin
      $display("FAIL %s latency: got %0d want 5", nm, lat);
    end else pass++;
    total++;
    if (pl != 1 || busy !== 1'b0) begin
      $display("FAIL %s pulse: got %0d busy %b want 1 busy 0",
               nm, pl, busy);
    end else pass++;
  endtask

  task automatic test_busy_guard;
    int lat;
    int pl;
    logic [17:0] got;
    logic [17:0] e;
    issue(16'h0F0F, 16'h1111, 1'b0, 1'b0, 1'b1, lat, got, pl);
    e = exp_q.pop_front();
    total++;
    if (got !== e) begin
      $display("FAIL guard result: got %h want %h", got, e);
    end else pass++;
    total++;
    if (pl != 1) begin
      $display("FAIL guard pulses: got %0d want 1", pl);
    end else pass++;
    total++;
    if (sum !== e[15:0]) begin
      $display("FAIL guard hold: got %h want %h", sum, e[15:0]);
    end else pass++;
  endtask

  task automatic test_reset_mid_run;
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (busy !== 1'b1 || sum[7:0] !== 8'h33) begin
      $display("FAIL midrun pre: got busy %b sum %h want 1 xx33",
               busy, sum);
    end else pass++;
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy, done, sum, cout, overflow} !== 20'd0) begin
      $display("FAIL midrun abort: got %h want 0",
               {busy, done, sum, cout, overflow});
    end else pass++;
    @(negedge clk);
    rst_n = 1'b1;
    test_vec("after_rst", 16'hABCD, 16'h1234, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back;
    logic [15:0] x;
    logic [15:0] y;
    for (int i = 0; i < 6; i++) begin
      x = 16'($urandom);
      y = 16'($urandom);
      test_vec("rand", x, y, 1'($urandom), 1'b0);
    end
  endtask

`ifdef CLA_SUB_EN
  task automatic test_sub;
    test_vec("sub5m7", 16'h0005, 16'h0007, 1'b0, 1'b1);
    total++;
    if (sum !== 16'hFFFE || cout !== 1'b0) begin
      $display("FAIL sub5m7 const: got %h %b want fffe 0", sum, cout);
    end else pass++;
    test_vec("sub7m5", 16'h0007, 16'h0005, 1'b1, 1'b1);
    total++;
    if (sum !== 16'h0002 || cout !== 1'b1) begin
      $display("FAIL sub7m5 const: got %h %b want 0002 1", sum, cout);
    end else pass++;
    test_vec("sub8000", 16'h8000, 16'h0001, 1'b0, 1'b1);
  endtask
`endif

  initial begin
    #2;
    test_reset();
    #20;
    @(negedge clk);
    rst_n = 1'b1;
    test_vec("add", 16'h1234, 16'h4321, 1'b0, 1'b0);
    total++;
    if (sum !== 16'h5555 || cout !== 1'b0 || overflow !== 1'b0) begin
      $display("FAIL add const: got %h %b %b want 5555 0 0",
               sum, cout, overflow);
    end else pass++;
    test_vec("ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    total++;
    if (sum !== 16'h0000 || cout !== 1'b1 || overflow !== 1'b0) begin
      $display("FAIL ripple const: got %h %b %b want 0000 1 0",
               sum, cout, overflow);
    end else pass++;
    test_vec("ovf", 16'h7FFF, 16'h0000, 1'b1, 1'b0);
    total++;
    if (sum !== 16'h8000 || cout !== 1'b0 || overflow !== 1'b1) begin
      $display("FAIL ovf const: got %h %b %b want 8000 0 1",
               sum, cout, overflow);
    end else pass++;
    test_vec("negovf", 16'h8000, 16'h8000, 1'b0, 1'b0);
    test_busy_guard();
    test_reset_mid_run();
    test_back_to_back();
`ifdef CLA_SUB_EN
    test_sub();
`endif
    total++;
    if (exp_q.size() != 0) begin
      $display("FAIL scoreboard: got %0d left want 0", exp_q.size());
    end else pass++;
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
